cliff_game_core: RTL and testbench

Parametrised, single-clock engine for the LED cliff game. A block of GROUP_W lit LEDs walks along an LED_W-wide strip toward cliff regions set by switch margins, at a player-selected speed. It tracks a score and flags a loss. It replaces derived game/debounce clocks with clock-enable ticks and sits between the button debouncers (single-cycle pulse inputs) and the LED/seven-segment drivers.

---
 rtl/cliff_game_core.sv | 181 ++++++++++++++++++
 tb/tb_cliff_game_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cliff_game_core.sv
// LED cliff game engine: a lit group walks toward switch-set cliffs at a selectable
// speed, using clock-enable ticks instead of derived clocks.
module cliff_game_core #(
    parameter int LED_W          = 16,
    parameter int GROUP_W        = 3,
    parameter int START_POS      = 6,
    parameter int NUM_SPEEDS     = 3,
    parameter int BASE_PERIOD    = 50000000,
    parameter int BLINK_PERIOD   = 5000000,
    parameter int SHOW_CLIFF_RUN = 0,
    localparam int MW            = $clog2(LED_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_p,
    input  logic             left_p,
    input  logic             right_p,
    input  logic             up_p,
    input  logic             down_p,
    input  logic [MW-1:0]    margin_l,
    input  logic [MW-1:0]    margin_r,
    output logic [LED_W-1:0] led,
    output logic [1:0]       state,
    output logic [2:0]       speed,
    output logic [MW-1:0]    pos,
    output logic [15:0]      score,
    output logic             lose
);
    localparam int CW = $clog2(BASE_PERIOD + 1);
    localparam int BW = $clog2(BLINK_PERIOD + 1);
    localparam logic [MW-1:0]    POS_MAX   = MW'(LED_W - GROUP_W);
    localparam logic [MW-1:0]    START_V   = MW'(START_POS);
    localparam logic [2:0]       SPEED_MAX = 3'(NUM_SPEEDS - 1);
    localparam logic [CW-1:0]    BASE_V    = CW'(BASE_PERIOD);
    localparam logic [BW-1:0]    BLINK_M1  = BW'(BLINK_PERIOD - 1);
    localparam logic [LED_W-1:0] GRP       = LED_W'((1 << GROUP_W) - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_LOST = 2'd2} state_t;
    typedef enum logic [1:0] {D_NONE = 2'd0, D_LEFT = 2'd1, D_RIGHT = 2'd2} dir_t;

    state_t            state_q, state_n;
    dir_t              dir_q, dir_n;
    logic [MW-1:0]     pos_n;
    logic [2:0]        speed_n, speed_upd;
    logic [15:0]       score_n;
    logic [LED_W-1:0]  led_n, cliff, group;
    logic              lose_n;
    logic [CW-1:0]     tick_cnt, tick_cnt_n, shifted, period_m1;
    logic [BW-1:0]     blink_cnt, blink_cnt_n;
    logic              blink_on, blink_on_n;
    logic [MW+1:0]     hi_edge;
    logic              unsafe, tick, go_lost;

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= D_NONE;
            pos       <= START_V;
            speed     <= '0;
            score     <= '0;
            lose      <= 1'b0;
            led       <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else begin
            state_q   <= state_n;
            dir_q     <= dir_n;
            pos       <= pos_n;
            speed     <= speed_n;
            score     <= score_n;
            lose      <= lose_n;
            led       <= led_n;
            tick_cnt  <= tick_cnt_n;
            blink_cnt <= blink_cnt_n;
            blink_on  <= blink_on_n;
        end
    end

    always_comb begin
        cliff = '0;
        for (int unsigned i = 0; i < LED_W; i++)
            cliff[i] = (i < 32'(margin_r)) || (i + 32'(margin_l) >= LED_W);

        hi_edge = (MW+2)'(pos) + (MW+2)'(GROUP_W) + (MW+2)'(margin_l);
        unsafe  = (pos < margin_r) || (hi_edge > (MW+2)'(LED_W));

        shifted   = BASE_V >> speed;
        period_m1 = (shifted == '0) ? '0 : shifted - CW'(1);
        tick      = (state_q == S_RUN) && (tick_cnt == period_m1);

        speed_upd = speed;
        if (up_p) begin
            if (speed != SPEED_MAX) speed_upd = speed + 3'd1;
        end else if (down_p && speed != 3'd0) begin
            speed_upd = speed - 3'd1;
        end
    end

    always_comb begin
        state_n     = state_q;
        dir_n       = dir_q;
        pos_n       = pos;
        speed_n     = speed;
        score_n     = score;
        tick_cnt_n  = '0;
        blink_cnt_n = blink_cnt;
        blink_on_n  = blink_on;
        go_lost     = 1'b0;

        case (state_q)
            S_IDLE: begin
                speed_n = speed_upd;
                if (start_p) begin
                    if (!unsafe) begin
                        state_n = S_RUN;
                        dir_n   = D_NONE;
                        score_n = '0;
                    end
                end else if (left_p && !right_p) begin
                    if (pos != POS_MAX) pos_n = pos + MW'(1);
                end else if (right_p && !left_p) begin
                    if (pos != '0) pos_n = pos - MW'(1);
                end
            end
            S_RUN: begin
                if (start_p) begin
                    state_n = S_IDLE;
                    pos_n   = START_V;
                    speed_n = '0;
                    dir_n   = D_NONE;
                end else if (unsafe) begin
                    go_lost = 1'b1;
                end else if (tick && ((dir_q == D_LEFT && pos == POS_MAX) ||
                                      (dir_q == D_RIGHT && pos == '0))) begin
                    go_lost = 1'b1;
                end else begin
                    speed_n = speed_upd;
                    // A real speed change restarts the period; a saturated press does not.
                    tick_cnt_n = (tick || speed_upd != speed) ? '0 : tick_cnt + CW'(1);
                    if (tick && dir_q != D_NONE) begin
                        pos_n = (dir_q == D_LEFT) ? pos + MW'(1) : pos - MW'(1);
                        if (score != 16'hFFFF) score_n = score + 16'd1;
                    end
                    if (left_p && !right_p)      dir_n = D_LEFT;
                    else if (right_p && !left_p) dir_n = D_RIGHT;
                end
            end
            default: begin
                if (start_p) begin
                    state_n = S_IDLE;
                    pos_n   = START_V;
                    speed_n = '0;
                    dir_n   = D_NONE;
                end else if (blink_cnt == BLINK_M1) begin
                    blink_cnt_n = '0;
                    blink_on_n  = !blink_on;
                end else begin
                    blink_cnt_n = blink_cnt + BW'(1);
                end
            end
        endcase

        if (go_lost) begin
            state_n     = S_LOST;
            blink_cnt_n = '0;
            blink_on_n  = 1'b1;
        end

        // led is built from next-state values so it lines up with pos/state.
        group  = GRP << pos_n;
        lose_n = (state_n == S_LOST);
        case (state_n)
            S_IDLE:  led_n = group | cliff;
            S_RUN:   led_n = group | ((SHOW_CLIFF_RUN != 0) ? cliff : '0);
            default: led_n = blink_on_n ? '1 : '0;
        endcase
    end
endmodule

// File: tb/tb_cliff_game_core.sv
// Directed bench for cliff_game_core with short periods (BASE 8, BLINK 4).
module tb_cliff_game_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_p = 1'b0, left_p = 1'b0, right_p = 1'b0, up_p = 1'b0, down_p = 1'b0;
    logic [3:0]  margin_l = 4'd0, margin_r = 4'd0;
    logic [15:0] led;
    logic [1:0]  state;
    logic [2:0]  speed;
    logic [3:0]  pos;
    logic [15:0] score;
    logic        lose;
    int          checks = 0;
    int          errors = 0;

    cliff_game_core #(
        .LED_W(16), .GROUP_W(3), .START_POS(6), .NUM_SPEEDS(3),
        .BASE_PERIOD(8), .BLINK_PERIOD(4), .SHOW_CLIFF_RUN(0)
    ) dut (
        .clk(clk), .reset(reset), .start_p(start_p), .left_p(left_p), .right_p(right_p),
        .up_p(up_p), .down_p(down_p), .margin_l(margin_l), .margin_r(margin_r),
        .led(led), .state(state), .speed(speed), .pos(pos), .score(score), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        step(2);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL reset_led_held: got %h expected 0000", led); end
        checks++; if (lose !== 1'b0) begin errors++; $display("FAIL reset_lose: got %b expected 0", lose); end
        reset = 1'b0;
        step(1);
        checks++; if (led !== 16'h01C0) begin errors++; $display("FAIL reset_led: got %h expected 01c0", led); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (pos !== 4'd6) begin errors++; $display("FAIL reset_pos: got %0d expected 6", pos); end
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    endtask

    task automatic test_idle_move;
        margin_l = 4'd2; margin_r = 4'd2;
        step(1);
        checks++; if (led !== 16'hC1C3) begin errors++; $display("FAIL idle_margin_led: got %h expected c1c3", led); end
        down_p = 1'b1; step(1); down_p = 1'b0;
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL idle_down_sat: got %0d expected 0", speed); end
        up_p = 1'b1; down_p = 1'b1; step(1); up_p = 1'b0; down_p = 1'b0;
        checks++; if (speed !== 3'd1) begin errors++; $display("FAIL idle_up_wins: got %0d expected 1", speed); end
        down_p = 1'b1; step(1); down_p = 1'b0;
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL idle_down: got %0d expected 0", speed); end
        for (int i = 0; i < 3; i++) begin left_p = 1'b1; step(1); left_p = 1'b0; end
        checks++; if (pos !== 4'd9) begin errors++; $display("FAIL idle_left3_pos: got %0d expected 9", pos); end
        checks++; if (led !== 16'hCE03) begin errors++; $display("FAIL idle_left3_led: got %h expected ce03", led); end
        left_p = 1'b1; right_p = 1'b1; step(1); left_p = 1'b0; right_p = 1'b0;
        checks++; if (pos !== 4'd9) begin errors++; $display("FAIL idle_both_pos: got %0d expected 9", pos); end
        for (int i = 0; i < 10; i++) begin left_p = 1'b1; step(1); left_p = 1'b0; end
        checks++; if (pos !== 4'd13) begin errors++; $display("FAIL idle_clamp_hi_pos: got %0d expected 13", pos); end
        checks++; if (led !== 16'hE003) begin errors++; $display("FAIL idle_clamp_hi_led: got %h expected e003", led); end
        for (int i = 0; i < 20; i++) begin right_p = 1'b1; step(1); right_p = 1'b0; end
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL idle_clamp_lo_pos: got %0d expected 0", pos); end
        checks++; if (led !== 16'hC007) begin errors++; $display("FAIL idle_clamp_lo_led: got %h expected c007", led); end
        for (int i = 0; i < 6; i++) begin left_p = 1'b1; step(1); left_p = 1'b0; end
        checks++; if (pos !== 4'd6) begin errors++; $display("FAIL idle_return_pos: got %0d expected 6", pos); end
    endtask

    task automatic test_unsafe_start;
        margin_l = 4'd0; margin_r = 4'd7;
        step(1);
        checks++; if (led !== 16'h01FF) begin errors++; $display("FAIL unsafe_led: got %h expected 01ff", led); end
        start_p = 1'b1; step(1); start_p = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL unsafe_start_state: got %0d expected 0", state); end
        checks++; if (pos !== 4'd6) begin errors++; $display("FAIL unsafe_start_pos: got %0d expected 6", pos); end
    endtask

    task automatic test_run_speed;
        margin_l = 4'd0; margin_r = 4'd0;
        start_p = 1'b1; step(1); start_p = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_enter_state: got %0d expected 1", state); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL run_enter_score: got %0d expected 0", score); end
        left_p = 1'b1; step(1); left_p = 1'b0;
        step(6);
        checks++; if (pos !== 4'd6) begin errors++; $display("FAIL run_before_tick_pos: got %0d expected 6", pos); end
        step(1);
        checks++; if (pos !== 4'd7 || score !== 16'd1) begin errors++; $display("FAIL run_tick1: got pos %0d score %0d expected 7 1", pos, score); end
        step(8);
        checks++; if (pos !== 4'd8 || score !== 16'd2) begin errors++; $display("FAIL run_tick2: got pos %0d score %0d expected 8 2", pos, score); end
        step(8);
        checks++; if (pos !== 4'd9 || score !== 16'd3) begin errors++; $display("FAIL run_tick3: got pos %0d score %0d expected 9 3", pos, score); end
        up_p = 1'b1; step(1); up_p = 1'b0;
        up_p = 1'b1; step(1); up_p = 1'b0;
        checks++; if (speed !== 3'd2 || pos !== 4'd9) begin errors++; $display("FAIL run_speed2: got speed %0d pos %0d expected 2 9", speed, pos); end
        step(2);
        checks++; if (pos !== 4'd10 || score !== 16'd4) begin errors++; $display("FAIL run_fast_tick: got pos %0d score %0d expected 10 4", pos, score); end
        checks++; if (led !== 16'h1C00 || lose !== 1'b0) begin errors++; $display("FAIL run_led: got %h lose %b expected 1c00 0", led, lose); end
        up_p = 1'b1; step(1); up_p = 1'b0;
        checks++; if (speed !== 3'd2 || pos !== 4'd10) begin errors++; $display("FAIL run_speed_sat: got speed %0d pos %0d expected 2 10", speed, pos); end
        step(1);
        checks++; if (pos !== 4'd11 || score !== 16'd5) begin errors++; $display("FAIL run_fast_tick2: got pos %0d score %0d expected 11 5", pos, score); end
        step(5);
        checks++; if (state !== 2'd1 || pos !== 4'd13) begin errors++; $display("FAIL run_at_edge: got state %0d pos %0d expected 1 13", state, pos); end
        step(1);
        checks++; if (state !== 2'd2 || pos !== 4'd13 || score !== 16'd7) begin errors++; $display("FAIL offstrip_loss: got state %0d pos %0d score %0d expected 2 13 7", state, pos, score); end
        checks++; if (lose !== 1'b1 || led !== 16'hFFFF) begin errors++; $display("FAIL offstrip_led: got lose %b led %h expected 1 ffff", lose, led); end
        down_p = 1'b1; step(1); down_p = 1'b0;
        checks++; if (speed !== 3'd2) begin errors++; $display("FAIL lost_speed_ignored: got %0d expected 2", speed); end
        start_p = 1'b1; step(1); start_p = 1'b0;
        checks++; if (state !== 2'd0 || pos !== 4'd6 || speed !== 3'd0 || score !== 16'd7) begin errors++; $display("FAIL lost_restart: got state %0d pos %0d speed %0d score %0d expected 0 6 0 7", state, pos, speed, score); end
        checks++; if (lose !== 1'b0 || led !== 16'h01C0) begin errors++; $display("FAIL lost_restart_led: got lose %b led %h expected 0 01c0", lose, led); end
    endtask

    task automatic test_cliff_loss;
        margin_l = 4'd0; margin_r = 4'd4;
        start_p = 1'b1; step(1); start_p = 1'b0;
        right_p = 1'b1; step(1); right_p = 1'b0;
        step(7);
        checks++; if (pos !== 4'd5 || score !== 16'd1) begin errors++; $display("FAIL cliff_tick1: got pos %0d score %0d expected 5 1", pos, score); end
        step(8);
        checks++; if (pos !== 4'd4 || state !== 2'd1) begin errors++; $display("FAIL cliff_pos4: got pos %0d state %0d expected 4 1", pos, state); end
        step(8);
        checks++; if (pos !== 4'd3 || state !== 2'd1) begin errors++; $display("FAIL cliff_pos3: got pos %0d state %0d expected 3 1", pos, state); end
        step(1);
        checks++; if (state !== 2'd2 || lose !== 1'b1 || led !== 16'hFFFF) begin errors++; $display("FAIL cliff_loss: got state %0d lose %b led %h expected 2 1 ffff", state, lose, led); end
        checks++; if (pos !== 4'd3 || score !== 16'd3) begin errors++; $display("FAIL cliff_loss_pos: got pos %0d score %0d expected 3 3", pos, score); end
        step(3);
        checks++; if (led !== 16'hFFFF) begin errors++; $display("FAIL blink_on_last: got %h expected ffff", led); end
        step(1);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL blink_off_first: got %h expected 0000", led); end
        step(3);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL blink_off_last: got %h expected 0000", led); end
        step(1);
        checks++; if (led !== 16'hFFFF) begin errors++; $display("FAIL blink_on_again: got %h expected ffff", led); end
        start_p = 1'b1; step(1); start_p = 1'b0;
        checks++; if (state !== 2'd0 || pos !== 4'd6 || score !== 16'd3 || led !== 16'h01CF) begin errors++; $display("FAIL cliff_restart: got state %0d pos %0d score %0d led %h expected 0 6 3 01cf", state, pos, score, led); end
    endtask

    task automatic test_margin_change;
        margin_l = 4'd0; margin_r = 4'd0;
        start_p = 1'b1; step(1); start_p = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL margin_run_state: got %0d expected 1", state); end
        margin_r = 4'd7;
        step(1);
        checks++; if (state !== 2'd2 || lose !== 1'b1) begin errors++; $display("FAIL margin_loss: got state %0d lose %b expected 2 1", state, lose); end
        start_p = 1'b1; step(1); start_p = 1'b0;
        margin_r = 4'd0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL margin_restart: got %0d expected 0", state); end
    endtask

    task automatic test_abort;
        start_p = 1'b1; step(1); start_p = 1'b0;
        left_p = 1'b1; step(1); left_p = 1'b0;
        step(7);
        checks++; if (pos !== 4'd7 || score !== 16'd1) begin errors++; $display("FAIL abort_pre: got pos %0d score %0d expected 7 1", pos, score); end
        up_p = 1'b1; step(1); up_p = 1'b0;
        checks++; if (speed !== 3'd1) begin errors++; $display("FAIL abort_speed: got %0d expected 1", speed); end
        start_p = 1'b1; step(1); start_p = 1'b0;
        checks++; if (state !== 2'd0 || pos !== 4'd6 || speed !== 3'd0 || score !== 16'd1) begin errors++; $display("FAIL abort: got state %0d pos %0d speed %0d score %0d expected 0 6 0 1", state, pos, speed, score); end
    endtask

    task automatic test_async_reset;
        start_p = 1'b1; step(1); start_p = 1'b0;
        checks++; if (state !== 2'd1 || score !== 16'd0) begin errors++; $display("FAIL areset_run: got state %0d score %0d expected 1 0", state, score); end
        left_p = 1'b1; step(1); left_p = 1'b0;
        step(3);
        #2 reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || pos !== 4'd6 || led !== 16'h0000 || lose !== 1'b0) begin errors++; $display("FAIL areset_immediate: got state %0d pos %0d led %h lose %b expected 0 6 0000 0", state, pos, led, lose); end
        @(negedge clk);
        reset = 1'b0;
        step(1);
        checks++; if (state !== 2'd0 || led !== 16'h01C0) begin errors++; $display("FAIL areset_release: got state %0d led %h expected 0 01c0", state, led); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_move();
        test_unsafe_start();
        test_run_speed();
        test_cliff_loss();
        test_margin_change();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
